// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - return address stack with overflow wrap, push+pop replace and single-level checkpoint
//
// Purpose: predicts return targets for JAL/JALR decoded from the EX-stage instruction,
//          and repairs its top-of-stack state from a snapshot on a misprediction flush.
// Optional feature: define RAS_STATS_EN to add saturating overflow/underflow counters.
// Ports:
//   clk_i              clock, rising edge
//   rst_i              asynchronous active-high reset
//   stall_i            pipeline stall; suppresses push/pop/replace and checkpoint save
//   ex_instr_i         EX-stage RISC-V instruction (opcode [6:0], rd [11:7], rs1 [19:15])
//   ex_pcp4_i          EX-stage PC+4, the value pushed
//   ckpt_save_i        snapshot {tos, count, mem[tos]}
//   ckpt_restore_i     roll back to the snapshot; ignores stall
//   target_addr_out_o  entry at top of stack, 0 when empty
//   empty_o / full_o   count == 0 / count == DEPTH
//   count_o            valid entries, 0..DEPTH
//   ckpt_valid_o       a snapshot is held
//   ovf_cnt_o          (RAS_STATS_EN) pushes while full, saturating
//   unf_cnt_o          (RAS_STATS_EN) pops while empty, saturating
module ras_ckpt #(
    parameter int RAS_INDEX = 3,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic [31:0]          ex_instr_i,
    input  logic [ADDR_W-1:0]    ex_pcp4_i,
    input  logic                 ckpt_save_i,
    input  logic                 ckpt_restore_i,
    output logic [ADDR_W-1:0]    target_addr_out_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [RAS_INDEX:0]   count_o,
    output logic                 ckpt_valid_o
`ifdef RAS_STATS_EN
    ,
    output logic [15:0]          ovf_cnt_o,
    output logic [15:0]          unf_cnt_o
`endif
);
    localparam int DEPTH = 1 << RAS_INDEX;
    localparam int CNT_W = RAS_INDEX + 1;
    localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
    localparam logic [RAS_INDEX-1:0] TOS_ONE = RAS_INDEX'(1);
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic [ADDR_W-1:0]    mem_q [DEPTH];
    logic [RAS_INDEX-1:0] tos_q, tos_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [RAS_INDEX-1:0] snap_tos_q, snap_tos_d;
    logic [CNT_W-1:0]     snap_count_q, snap_count_d;
    logic [ADDR_W-1:0]    snap_data_q, snap_data_d;
    logic                 ckpt_valid_q, ckpt_valid_d;

    logic                 wr_en;
    logic [RAS_INDEX-1:0] wr_idx;
    logic [ADDR_W-1:0]    wr_data;
    logic                 ovf_evt, unf_evt;

    logic [6:0] opcode;
    logic [4:0] rd, rs1;
    logic       is_jal, is_jalr, active, rd_link, rs1_link;
    logic       do_push, do_pop, do_repl;
    logic       unused_instr_bits;

    assign opcode  = ex_instr_i[6:0];
    assign rd      = ex_instr_i[11:7];
    assign rs1     = ex_instr_i[19:15];
    assign unused_instr_bits = ^{ex_instr_i[31:20], ex_instr_i[14:12]};

    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign active   = (is_jal || is_jalr) && !stall_i;
    assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
    // JAL has no rs1 field, so those bits must never be read as a link register.
    assign rs1_link = is_jalr && ((rs1 == 5'd1) || (rs1 == 5'd5));

    assign do_push = active && rd_link && (!rs1_link || (rd == rs1));
    assign do_pop  = active && !rd_link && rs1_link;
    assign do_repl = active && rd_link && rs1_link && (rd != rs1);

    always_comb begin
        tos_d        = tos_q;
        count_d      = count_q;
        snap_tos_d   = snap_tos_q;
        snap_count_d = snap_count_q;
        snap_data_d  = snap_data_q;
        ckpt_valid_d = ckpt_valid_q;
        wr_en        = 1'b0;
        wr_idx       = tos_q;
        wr_data      = ex_pcp4_i;
        ovf_evt      = 1'b0;
        unf_evt      = 1'b0;

        if (ckpt_restore_i) begin
            // Restore wins over any stack op and any save in the same cycle.
            if (ckpt_valid_q) begin
                tos_d        = snap_tos_q;
                count_d      = snap_count_q;
                wr_en        = 1'b1;
                wr_idx       = snap_tos_q;
                wr_data      = snap_data_q;
                ckpt_valid_d = 1'b0;
            end
        end else begin
            // Replace on an empty stack has nothing to replace, so it becomes a push.
            if (do_push || (do_repl && count_q == '0)) begin
                tos_d  = tos_q + TOS_ONE;
                wr_en  = 1'b1;
                wr_idx = tos_q + TOS_ONE;
                if (count_q == DEPTH_C) begin
                    ovf_evt = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end else if (do_repl) begin
                wr_en = 1'b1;
            end else if (do_pop) begin
                if (count_q != '0) begin
                    tos_d   = tos_q - TOS_ONE;
                    count_d = count_q - CNT_ONE;
                end else begin
                    unf_evt = 1'b1;
                end
            end
            if (ckpt_save_i && !stall_i) begin
                snap_tos_d   = tos_q;
                snap_count_d = count_q;
                snap_data_d  = mem_q[tos_q];
                ckpt_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            tos_q        <= '0;
            count_q      <= '0;
            snap_tos_q   <= '0;
            snap_count_q <= '0;
            snap_data_q  <= '0;
            ckpt_valid_q <= 1'b0;
        end else begin
            if (wr_en) mem_q[wr_idx] <= wr_data;
            tos_q        <= tos_d;
            count_q      <= count_d;
            snap_tos_q   <= snap_tos_d;
            snap_count_q <= snap_count_d;
            snap_data_q  <= snap_data_d;
            ckpt_valid_q <= ckpt_valid_d;
        end
    end

    assign target_addr_out_o = (count_q != '0) ? mem_q[tos_q] : '0;
    assign empty_o           = (count_q == '0);
    assign full_o            = (count_q == DEPTH_C);
    assign count_o           = count_q;
    assign ckpt_valid_o      = ckpt_valid_q;

`ifdef RAS_STATS_EN
    logic [15:0] ovf_q, unf_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            if (ovf_evt && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
            if (unf_evt && unf_q != 16'hFFFF) unf_q <= unf_q + 16'd1;
        end
    end
    assign ovf_cnt_o = ovf_q;
    assign unf_cnt_o = unf_q;
`else
    logic unused_stats;
    assign unused_stats = ovf_evt ^ unf_evt ^ unused_instr_bits;
`endif
endmodule

// File: tb/tb_ras_ckpt.sv
// tb/tb_ras_ckpt.sv - directed self-checking bench for ras_ckpt
module tb_ras_ckpt;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] ex_instr;
    logic [31:0] ex_pcp4;
    logic        ckpt_save;
    logic        ckpt_restore;
    logic [31:0] target;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        ckpt_valid;
`ifdef RAS_STATS_EN
    logic [15:0] ovf_cnt;
    logic [15:0] unf_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ras_ckpt #(.RAS_INDEX(3), .ADDR_W(32)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .stall_i           (stall),
        .ex_instr_i        (ex_instr),
        .ex_pcp4_i         (ex_pcp4),
        .ckpt_save_i       (ckpt_save),
        .ckpt_restore_i    (ckpt_restore),
        .target_addr_out_o (target),
        .empty_o           (empty),
        .full_o            (full),
        .count_o           (count),
        .ckpt_valid_o      (ckpt_valid)
`ifdef RAS_STATS_EN
        ,
        .ovf_cnt_o         (ovf_cnt),
        .unf_cnt_o         (unf_cnt)
`endif
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd_f, input logic [4:0] rs1_f);
        return {12'b0, rs1_f, 3'b0, rd_f, op};
    endfunction

    // One clock of stimulus; outputs are settled 1 time unit after the edge.
    task automatic cyc(input logic [31:0] ins, input logic [31:0] pc,
                       input logic sv, input logic rs, input logic st);
        ex_instr     = ins;
        ex_pcp4      = pc;
        ckpt_save    = sv;
        ckpt_restore = rs;
        stall        = st;
        @(posedge clk);
        #1;
        ex_instr     = NOP;
        ex_pcp4      = '0;
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;
        stall        = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ex_instr = NOP; ex_pcp4 = '0; ckpt_save = 0; ckpt_restore = 0; stall = 0;
        do_reset();
        checks++; if (target !== 32'h0) begin failures++; $display("FAIL reset_target got=%h exp=%h", target, 32'h0); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (ckpt_valid !== 1'b0) begin failures++; $display("FAIL reset_ckpt_valid got=%b exp=0", ckpt_valid); end
    endtask

    task automatic test_push_pop();
        do_reset();
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'h100, 0, 0, 0);
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'h200, 0, 0, 0);
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL pp_count got=%0d exp=2", count); end
        checks++; if (target !== 32'h200) begin failures++; $display("FAIL pp_target got=%h exp=200", target); end
        cyc(mk(OP_JALR, 5'd0, 5'd1), 32'h0, 0, 0, 0);
        checks++; if (target !== 32'h100) begin failures++; $display("FAIL pp_pop_target got=%h exp=100", target); end
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL pp_pop_count got=%0d exp=1", count); end
        // jal with rs1 field = x1 must not pop; rd = x0 makes it a no-op.
        cyc(mk(OP_JAL, 5'd0, 5'd1), 32'h0, 0, 0, 0);
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL jal_rs1_ignored got=%0d exp=1", count); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) cyc(mk(OP_JAL, 5'd5, 5'd0), 32'(i * 16), 0, 0, 0);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
`ifdef RAS_STATS_EN
        checks++; if (ovf_cnt !== 16'd1) begin failures++; $display("FAIL ovf_cnt got=%0d exp=1", ovf_cnt); end
`endif
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (target !== 32'(32'h90 - i * 16)) begin
                failures++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, target, 32'(32'h90 - i * 16));
            end
            cyc(mk(OP_JALR, 5'd0, 5'd5), 32'h0, 0, 0, 0);
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_drained_empty got=%b exp=1", empty); end
    endtask

    task automatic test_underflow();
        do_reset();
        cyc(mk(OP_JALR, 5'd0, 5'd1), 32'h0, 0, 0, 0);
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL unf_count got=%0d exp=0", count); end
        checks++; if (target !== 32'h0) begin failures++; $display("FAIL unf_target got=%h exp=0", target); end
`ifdef RAS_STATS_EN
        checks++; if (unf_cnt !== 16'd1) begin failures++; $display("FAIL unf_cnt got=%0d exp=1", unf_cnt); end
`endif
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'h44, 0, 0, 0);
        checks++; if (target !== 32'h44) begin failures++; $display("FAIL unf_then_push got=%h exp=44", target); end
    endtask

    task automatic test_replace();
        do_reset();
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'hA0, 0, 0, 0);
        cyc(mk(OP_JALR, 5'd5, 5'd1), 32'hB0, 0, 0, 0);
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL repl_count got=%0d exp=1", count); end
        checks++; if (target !== 32'hB0) begin failures++; $display("FAIL repl_target got=%h exp=b0", target); end
        cyc(mk(OP_JALR, 5'd1, 5'd1), 32'hC0, 0, 0, 0);
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL same_link_push_count got=%0d exp=2", count); end
        checks++; if (target !== 32'hC0) begin failures++; $display("FAIL same_link_push_target got=%h exp=c0", target); end
        do_reset();
        cyc(mk(OP_JALR, 5'd1, 5'd5), 32'hD0, 0, 0, 0);
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL repl_empty_count got=%0d exp=1", count); end
        checks++; if (target !== 32'hD0) begin failures++; $display("FAIL repl_empty_target got=%h exp=d0", target); end
    endtask

    task automatic test_ckpt();
        do_reset();
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'hA0, 0, 0, 0);
        cyc(NOP, 32'h0, 1, 0, 0);
        checks++; if (ckpt_valid !== 1'b1) begin failures++; $display("FAIL ckpt_valid_set got=%b exp=1", ckpt_valid); end
        cyc(mk(OP_JALR, 5'd0, 5'd1), 32'h0, 0, 0, 0);
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'hC0, 0, 0, 0);
        checks++; if (target !== 32'hC0) begin failures++; $display("FAIL ckpt_spec_target got=%h exp=c0", target); end
        cyc(NOP, 32'h0, 0, 1, 0);
        checks++; if (target !== 32'hA0) begin failures++; $display("FAIL ckpt_restore_target got=%h exp=a0", target); end
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL ckpt_restore_count got=%0d exp=1", count); end
        checks++; if (ckpt_valid !== 1'b0) begin failures++; $display("FAIL ckpt_valid_clr got=%b exp=0", ckpt_valid); end
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'hD0, 0, 0, 0);
        cyc(NOP, 32'h0, 1, 0, 0);
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'hE0, 0, 0, 0);
        // save + restore + pop together: restore wins, the save is dropped.
        cyc(mk(OP_JALR, 5'd0, 5'd1), 32'h0, 1, 1, 0);
        checks++; if (target !== 32'hD0) begin failures++; $display("FAIL save_restore_target got=%h exp=d0", target); end
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL save_restore_count got=%0d exp=2", count); end
        checks++; if (ckpt_valid !== 1'b0) begin failures++; $display("FAIL save_restore_valid got=%b exp=0", ckpt_valid); end
        // restore with no snapshot: concurrent push is discarded.
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'hF0, 0, 1, 0);
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL restore_novalid_count got=%0d exp=2", count); end
        checks++; if (target !== 32'hD0) begin failures++; $display("FAIL restore_novalid_target got=%h exp=d0", target); end
        cyc(NOP, 32'h0, 1, 0, 1);
        checks++; if (ckpt_valid !== 1'b0) begin failures++; $display("FAIL stall_save_valid got=%b exp=0", ckpt_valid); end
    endtask

    task automatic test_stall_and_reset();
        do_reset();
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'h300, 0, 0, 1);
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL stall_push_count got=%0d exp=0", count); end
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'h300, 0, 0, 0);
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'h400, 1, 0, 1);
        checks++; if (target !== 32'h300) begin failures++; $display("FAIL stall_target got=%h exp=300", target); end
        cyc(mk(OP_JAL, 5'd1, 5'd0), 32'h500, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL async_rst_count got=%0d exp=0", count); end
        checks++; if (target !== 32'h0) begin failures++; $display("FAIL async_rst_target got=%h exp=0", target); end
        checks++; if (ckpt_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", ckpt_valid); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL async_rst_empty got=%b exp=1", empty); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_ckpt();
        test_stall_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
